// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: instruction fetch vs data access, data-priority with
// bounded fetch starvation, registered grant, sticky RAM timeout flag.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC
  } state_e;

  localparam logic [3:0]  STREAK_LIM = 4'(STARVE_MAX);
  localparam logic [15:0] WAIT_LIM   = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;
  logic        op_wr_q, op_wr_d;
  logic [3:0]  dstreak_q, dstreak_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;

  logic data_pend;
  logic grant_data;
  logic in_acc;

  always_comb begin
    state_d    = state_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    op_wr_d    = op_wr_q;
    dstreak_d  = dstreak_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;

    data_pend  = dREN | dWEN;
    grant_data = data_pend & (~iREN | (dstreak_q < STREAK_LIM));
    in_acc     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d    = D_ACC;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          op_wr_d    = dWEN;
          wcnt_d     = '0;
        end else if (iREN) begin
          state_d   = I_ACC;
          ramaddr_d = iaddr;
          wcnt_d    = '0;
        end
      end
      I_ACC, D_ACC: begin
        if (ramready) begin
          state_d = IDLE;
        end else if (wcnt_q == WAIT_LIM) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Streak counts data completions while a fetch is waiting; saturates at the limit.
    if (state_q == D_ACC && ramready) begin
      if (!iREN)
        dstreak_d = '0;
      else if (dstreak_q >= STREAK_LIM)
        dstreak_d = STREAK_LIM;
      else
        dstreak_d = dstreak_q + 4'd1;
    end else if (state_q == I_ACC && ramready) begin
      dstreak_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      op_wr_q    <= 1'b0;
      dstreak_q  <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      op_wr_q    <= op_wr_d;
      dstreak_q  <= dstreak_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    ramREN   = (state_q == I_ACC) | ((state_q == D_ACC) & ~op_wr_q);
    ramWEN   = (state_q == D_ACC) & op_wr_q;
    ihit     = (state_q == I_ACC) & ramready;
    dhit     = (state_q == D_ACC) & ramready;
    iload    = ihit ? ramload : '0;
    dload    = dhit ? ramload : '0;
    busy     = in_acc;
    err      = err_q;
    ramaddr  = ramaddr_q;
    ramstore = ramstore_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written starvation and
// timeout sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, busy, err;

  mem_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready),
    .busy(busy), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [133:0] pk(input logic ren, wen, ih, dh, bz, er,
                                      input logic [31:0] ad, st, il, dl);
    return {ren, wen, ih, dh, bz, er, ad, st, il, dl};
  endfunction

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (ren,wen,ihit,dhit,busy,err,addr,store,iload,dload)",
               nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: 0 idle, 1 fetch in flight, 2 data in flight.
  int          m_cur = 0;
  logic [31:0] m_addr = '0, m_store = '0;
  logic        m_wr = 1'b0, m_err = 1'b0;
  int          m_streak = 0, m_wait = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_cur <= 0; m_addr <= '0; m_store <= '0; m_wr <= 1'b0;
      m_streak <= 0; m_wait <= 0; m_err <= 1'b0;
    end else if (m_cur == 0) begin
      if ((dREN || dWEN) && (!iREN || m_streak < STARVE)) begin
        m_cur <= 2; m_addr <= daddr; m_store <= dstore; m_wr <= dWEN; m_wait <= 0;
      end else if (iREN) begin
        m_cur <= 1; m_addr <= iaddr; m_wait <= 0;
      end
    end else if (ramready) begin
      m_cur <= 0;
      if (m_cur == 2)
        m_streak <= iREN ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
      else
        m_streak <= 0;
    end else if (m_wait == TMO - 1) begin
      m_cur <= 0; m_err <= 1'b1;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  function automatic logic [133:0] model_out();
    logic ih, dh;
    ih = (m_cur == 1) && ramready;
    dh = (m_cur == 2) && ramready;
    return pk((m_cur == 1) || (m_cur == 2 && !m_wr), (m_cur == 2) && m_wr, ih, dh,
              m_cur != 0, m_err, m_addr, m_store,
              ih ? ramload : 32'h0, dh ? ramload : 32'h0);
  endfunction

  typedef struct packed {
    logic rst, iren; logic [31:0] iaddr; logic dren, dwen; logic [31:0] daddr, dstore;
    logic rr; logic [31:0] rl;
    logic e_ren, e_wen; logic [31:0] e_addr, e_store; logic e_ih; logic [31:0] e_il;
    logic e_dh; logic [31:0] e_dl; logic e_busy, e_err;
  } vec_t;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [31:0] Z = 32'h0;

  vec_t tbl [22];
  int   hseq [11];
  logic [31:0] haddr [11];

  task automatic newd();
    int k;
    k = $urandom_range(2);
    dREN = (k != 1); dWEN = (k != 0);
    daddr = $urandom; dstore = $urandom;
  endtask

  initial begin
    int nh, bcnt, hcnt, got;
    logic e8, e9, e13;
    logic [31:0] il;
    logic seen_ih, seen_dh;

    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    iaddr = Z; daddr = Z; dstore = Z; ramload = Z;

    //            rst iren iaddr        dren dwen daddr       dstore          rr rl
    //            ren wen addr          store           ih il              dh dl          busy err
    tbl[0]  = '{Y, N, Z,           N, N, Z,          Z,             N, Z,
                N, N, Z,           Z,             N, Z,           N, Z,          N, N};
    tbl[1]  = '{N, Y, 32'h40,      N, N, Z,          Z,             N, Z,
                N, N, Z,           Z,             N, Z,           N, Z,          N, N};
    tbl[2]  = '{N, Y, 32'h40,      N, N, Z,          Z,             N, Z,
                Y, N, 32'h40,      Z,             N, Z,           N, Z,          Y, N};
    tbl[3]  = tbl[2];
    tbl[4]  = '{N, Y, 32'h40,      N, N, Z,          Z,             Y, 32'h8C010004,
                Y, N, 32'h40,      Z,             Y, 32'h8C010004, N, Z,         Y, N};
    tbl[5]  = '{N, N, Z,           N, N, Z,          Z,             Y, 32'h1111,
                N, N, 32'h40,      Z,             N, Z,           N, Z,          N, N};
    tbl[6]  = '{N, N, Z,           N, Y, 32'h200,    32'hDEADBEEF,  N, Z,
                N, N, 32'h40,      Z,             N, Z,           N, Z,          N, N};
    tbl[7]  = '{N, N, Z,           N, Y, 32'h200,    32'hDEADBEEF,  Y, 32'h1234,
                N, Y, 32'h200,     32'hDEADBEEF,  N, Z,           Y, 32'h1234,   Y, N};
    tbl[8]  = '{N, N, Z,           N, N, Z,          Z,             N, Z,
                N, N, 32'h200,     32'hDEADBEEF,  N, Z,           N, Z,          N, N};
    tbl[9]  = '{N, N, Z,           Y, Y, 32'h204,    32'hCAFEF00D,  N, Z,
                N, N, 32'h200,     32'hDEADBEEF,  N, Z,           N, Z,          N, N};
    tbl[10] = '{N, N, Z,           Y, Y, 32'h204,    32'hCAFEF00D,  Y, 32'h5A5A,
                N, Y, 32'h204,     32'hCAFEF00D,  N, Z,           Y, 32'h5A5A,   Y, N};
    tbl[11] = '{N, N, Z,           N, N, Z,          Z,             N, Z,
                N, N, 32'h204,     32'hCAFEF00D,  N, Z,           N, Z,          N, N};
    tbl[12] = '{N, Y, 32'h44,      Y, N, 32'h100,    32'h55,        N, Z,
                N, N, 32'h204,     32'hCAFEF00D,  N, Z,           N, Z,          N, N};
    tbl[13] = '{N, Y, 32'h44,      Y, N, 32'h100,    32'h55,        N, Z,
                Y, N, 32'h100,     32'h55,        N, Z,           N, Z,          Y, N};
    tbl[14] = '{N, Y, 32'h44,      Y, N, 32'h100,    32'h55,        Y, 32'hAAAA,
                Y, N, 32'h100,     32'h55,        N, Z,           Y, 32'hAAAA,   Y, N};
    tbl[15] = '{N, Y, 32'h44,      N, N, Z,          Z,             N, Z,
                N, N, 32'h100,     32'h55,        N, Z,           N, Z,          N, N};
    tbl[16] = '{N, Y, 32'h44,      N, N, Z,          Z,             Y, 32'h77,
                Y, N, 32'h44,      32'h55,        Y, 32'h77,      N, Z,          Y, N};
    tbl[17] = '{N, N, Z,           N, N, Z,          Z,             N, Z,
                N, N, 32'h44,      32'h55,        N, Z,           N, Z,          N, N};
    tbl[18] = '{N, Y, 32'h80,      N, N, Z,          Z,             N, Z,
                N, N, 32'h44,      32'h55,        N, Z,           N, Z,          N, N};
    tbl[19] = '{N, Y, 32'h80,      N, N, Z,          Z,             N, Z,
                Y, N, 32'h80,      32'h55,        N, Z,           N, Z,          Y, N};
    tbl[20] = '{Y, Y, 32'h80,      N, N, Z,          Z,             N, Z,
                Y, N, 32'h80,      32'h55,        N, Z,           N, Z,          Y, N};
    tbl[21] = '{N, N, Z,           N, N, Z,          Z,             N, Z,
                N, N, Z,           Z,             N, Z,           N, Z,          N, N};

    repeat (2) @(posedge CLK);
    for (int i = 0; i < 22; i++) begin
      @(posedge CLK); #1;
      RST = tbl[i].rst; iREN = tbl[i].iren; iaddr = tbl[i].iaddr;
      dREN = tbl[i].dren; dWEN = tbl[i].dwen; daddr = tbl[i].daddr; dstore = tbl[i].dstore;
      ramready = tbl[i].rr; ramload = tbl[i].rl;
      @(negedge CLK);
      chk($sformatf("row%0d", i),
          pk(ramREN, ramWEN, ihit, dhit, busy, err, ramaddr, ramstore, iload, dload),
          pk(tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_ih, tbl[i].e_dh, tbl[i].e_busy,
             tbl[i].e_err, tbl[i].e_addr, tbl[i].e_store, tbl[i].e_il, tbl[i].e_dl));
    end

    // Starvation: fetch held, writes back-to-back; expect 4 data, 1 fetch, repeated.
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b0; dWEN = 1'b1; daddr = 32'h400;
    dstore = 32'h1; ramready = 1'b1; ramload = 32'h9;
    for (int k = 0; k < 11; k++) begin hseq[k] = 0; haddr[k] = Z; end
    nh = 0;
    for (int c = 0; c < 80 && nh < 11; c++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        hseq[nh] = ihit ? 1 : 2;
        haddr[nh] = ramaddr;
        nh++;
      end
      @(posedge CLK); #1;
    end
    iREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    for (int k = 0; k < 11; k++)
      chk_i($sformatf("starve_hit%0d", k), hseq[k], (k == 4 || k == 9) ? 1 : 2);
    chk_i("starve_fetch_addr", haddr[4], 32'h300);
    chk_i("starve_data_addr", haddr[5], 32'h400);

    // Timeout: data read, RAM never answers.
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h500; ramready = 1'b0;
    bcnt = 0; hcnt = 0; e8 = 1'b0; e9 = 1'b0; e13 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      if (busy) bcnt++;
      if (dhit) hcnt++;
      if (c == 8)  e8  = err;
      if (c == 9)  e9  = err;
      if (c == 13) e13 = err;
      @(posedge CLK); #1;
      if (c == 8) dREN = 1'b0;
    end
    chk_i("tmo_busy_cycles", bcnt, 8);
    chk_i("tmo_dhits", hcnt, 0);
    chk_i("tmo_err_c8", int'(e8), 0);
    chk_i("tmo_err_c9", int'(e9), 1);
    chk_i("tmo_err_c13", int'(e13), 1);

    iREN = 1'b1; iaddr = 32'h600; ramready = 1'b1; ramload = 32'h600D;
    got = 0; il = Z;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge CLK);
      if (ihit) begin got = 1; il = iload; end
      else begin @(posedge CLK); #1; end
    end
    chk_i("post_tmo_ihit", got, 1);
    chk_i("post_tmo_iload", il, 32'h600D);
    chk_i("post_tmo_err_sticky", int'(err), 1);
    @(posedge CLK); #1;
    iREN = 1'b0; ramready = 1'b0;

    // Randomized traffic against the model.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    seen_ih = 1'b0; seen_dh = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      chk($sformatf("rand_c%0d", c),
          pk(ramREN, ramWEN, ihit, dhit, busy, err, ramaddr, ramstore, iload, dload),
          model_out());
      seen_ih = ihit; seen_dh = dhit;
      @(posedge CLK); #1;
      RST = ($urandom_range(199) == 0);
      if (!iREN) begin
        if ($urandom_range(3) == 0) begin iREN = 1'b1; iaddr = $urandom; end
      end else if (seen_ih) begin
        iREN = 1'($urandom_range(1)); iaddr = $urandom;
      end
      if (!(dREN || dWEN)) begin
        if ($urandom_range(2) == 0) newd();
      end else if (seen_dh) begin
        if ($urandom_range(1) == 1) newd();
        else begin dREN = 1'b0; dWEN = 1'b0; end
      end
      ramready = ($urandom_range(2) == 0);
      ramload = $urandom;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter sitting between the datapath's instruction fetch port and its data port on one side and the shared RAM interface on the other. Grants one access at a time, data priority with a bounded-starvation guarantee for instruction fetch. Registers the granted address and store data for the whole RAM transaction. Reports a sticky error when RAM fails to respond.

## Interface
Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; legal range 1..15
- TIMEOUT, 1024, cycles a RAM access may wait for ramready before abort; legal range 1..65535

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction address
- iload  out  32  instruction data; valid while ihit
- ihit  out  1  one-cycle completion pulse for a fetch
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read data; valid while dhit
- dhit  out  1  one-cycle completion pulse for a data access
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address (registered)
- ramstore  out  32  RAM write data (registered)
- ramload  in  32  RAM read data
- ramready  in  1  RAM completion, valid only while an enable is high
- busy  out  1  high in I_ACC or D_ACC
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, I_ACC, D_ACC.
- IDLE, next-state decision on the current inputs:
  - Data pending (dREN|dWEN) and iREN low, or dstreak < STARVE_MAX: go D_ACC.
  - Data pending, iREN high, and dstreak == STARVE_MAX: go I_ACC.
  - Only iREN: go I_ACC.
  - Nothing pending: stay in IDLE.
- Grant capture, on the transition edge out of IDLE:
  - ramaddr <= granted address.
  - ramstore <= dstore on a data grant. On an instruction grant, ramstore holds its old value.
  - Latch op_wr = dWEN. When dREN and dWEN are both high, the access is a write.
- I_ACC: ramREN=1, ramWEN=0.
- D_ACC: ramWEN=op_wr, ramREN=~op_wr.
- In I_ACC or D_ACC, when ramready=1:
  - Assert ihit or dhit in the same cycle, combinationally.
  - iload/dload = ramload in that cycle.
  - Next state is IDLE.
- dstreak, width 4:
  - On dhit: dstreak <= (iREN ? dstreak+1 : 0), saturating at STARVE_MAX.
  - On ihit: dstreak <= 0.
- Timeout:
  - wcnt (16 bits) clears on entering an ACC state and increments each ACC cycle without ramready.
  - When wcnt == TIMEOUT-1 with no ramready: go IDLE, no hit, err <= 1. Enables drop the next cycle.
- err clears only on RST.
- Requesters must hold their request and address stable until the hit. A request dropped mid-access still completes to RAM, and the hit is still pulsed.
- iload/dload are 0 when their hit is low.

## Timing
- Reset values: state IDLE, all enables 0, ramaddr 0, ramstore 0, ihit/dhit 0, iload/dload 0, busy 0, err 0, dstreak 0, wcnt 0.
- RST asserted mid-access: abort next edge, no hit, enables low.
- Request seen in IDLE at cycle 0:
  - Enables high from cycle 1.
  - With ramready at cycle k ≥ 1, hit pulses at k.
  - State is IDLE at k+1; the next grant is decided at k+1, with enables at k+2.
  - Minimum request-to-hit latency: 1 cycle. One dead IDLE cycle between back-to-back transactions.
- ramready in IDLE is ignored.
- ramready in the same cycle as the timeout limit counts as completion: hit asserted, err not set.
- Enables never rise and fall in the same cycle. ramREN and ramWEN are never both high.

## Test plan
- Single fetch: iREN=1, iaddr=0x40, ramready at cycle 3 with ramload=0x8C010004 -> ihit=1 and iload=0x8C010004 at cycle 3 only; ramaddr=0x40 during cycles 1–3; busy low at cycle 4.
- Simultaneous requests with dstreak=0: iREN=1, dREN=1, daddr=0x100 -> D_ACC first with ramREN=1, ramaddr=0x100. After dhit, release dREN -> next grant is I_ACC.
- Starvation, STARVE_MAX=4: iREN held, dWEN re-asserted back-to-back -> exactly 4 dhits, then ihit, then data is granted again with dstreak=0.
- Write path: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramready at cycle 1 -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF at cycle 1, dhit at cycle 1. dREN=dWEN=1 gives an identical result.
- Timeout, TIMEOUT=8: dREN=1, ramready never asserted -> busy high for 8 cycles, no dhit, err=1 from cycle 9 and stays 1. A following fetch still completes normally.
- Reset mid-access: RST pulsed during I_ACC cycle 2 -> cycle 3 shows IDLE, ramREN=0, ihit never pulses, err=0.
